// File: rtl/usart_bus_sequencer.sv
// i8251 USART bus master: init recipe, status polling, byte streaming, CPU port.
// Optional USART_RX_FIFO_EN adds a 4-entry RX FIFO and an rx_ready input.
`timescale 1ns/1ps
module usart_bus_sequencer #(
  parameter logic [7:0] MODE_WORD  = 8'h4E,
  parameter logic [7:0] CMD_WORD   = 8'h15,
  parameter int         STROBE_CYC = 4,
  parameter int         POLL_GAP   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       cpu_cd,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_ack,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
`ifdef USART_RX_FIFO_EN
  input  logic       rx_ready,
`endif
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic [7:0] status,
  output logic       init_done,
  output logic       u_cs_n,
  output logic       u_wr_n,
  output logic       u_rd_n,
  output logic       u_cd,
  output logic [7:0] u_dout,
  output logic       u_oe,
  input  logic [7:0] u_din
);

  typedef enum logic [3:0] {
    INIT0, INIT1, INIT2, INIT_IR, INIT_MODE, INIT_CMD,
    POLL_WAIT, STAT_RD, RX_RD, TX_WR, CPU
  } st_e;

  typedef enum logic [2:0] {
    PH_IDLE, PH_SETUP, PH_STROBE, PH_HOLD, PH_GAP
  } ph_e;

  st_e        st_q, st_d, nxt;
  ph_e        ph_q, ph_d;
  logic [3:0] scnt_q, scnt_d;
  logic [7:0] gap_q, gap_d;
  logic       we_q, we_d;
  logic       cd_q, cd_d;
  logic [7:0] dout_q, dout_d;
  logic [7:0] samp_q, samp_d;
  logic [7:0] status_q, status_d;
  logic [7:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       init_done_q, init_done_d;

  logic       f_we, f_cd;
  logic [7:0] f_dat;
  logic       cur_we, cur_cd;
  logic [7:0] cur_dat;
  logic       in_gap, busy, reinit, rx_ok, rx_push;

  // Bus fields for the access the current state starts
  always_comb begin
    f_we  = 1'b0;
    f_cd  = 1'b0;
    f_dat = 8'h00;
    unique case (st_q)
      INIT0, INIT1, INIT2: begin
        f_we = 1'b1;
        f_cd = 1'b1;
      end
      INIT_IR: begin
        f_we  = 1'b1;
        f_cd  = 1'b1;
        f_dat = 8'h40;
      end
      INIT_MODE: begin
        f_we  = 1'b1;
        f_cd  = 1'b1;
        f_dat = MODE_WORD;
      end
      INIT_CMD: begin
        f_we  = 1'b1;
        f_cd  = 1'b1;
        f_dat = CMD_WORD;
      end
      STAT_RD: f_cd = 1'b1;
      TX_WR: begin
        f_we  = 1'b1;
        f_dat = tx_data;
      end
      CPU: begin
        f_we  = cpu_we;
        f_cd  = cpu_cd;
        f_dat = cpu_wdata;
      end
      default: ;
    endcase
  end

  assign cur_we  = (ph_q == PH_SETUP) ? f_we  : we_q;
  assign cur_cd  = (ph_q == PH_SETUP) ? f_cd  : cd_q;
  assign cur_dat = (ph_q == PH_SETUP) ? f_dat : dout_q;
  assign in_gap  = (ph_q == PH_GAP);
  assign reinit  = we_q & cd_q & dout_q[6];
  assign rx_push = (st_q == RX_RD) & in_gap;

  always_comb begin
    nxt = POLL_WAIT;
    unique case (st_q)
      INIT0:     nxt = INIT1;
      INIT1:     nxt = INIT2;
      INIT2:     nxt = INIT_IR;
      INIT_IR:   nxt = INIT_MODE;
      INIT_MODE: nxt = INIT_CMD;
      STAT_RD: begin
        if (cpu_req)                 nxt = CPU;
        else if (samp_q[1] & rx_ok)  nxt = RX_RD;
        else if (samp_q[0] & tx_valid) nxt = TX_WR;
      end
      RX_RD: begin
        if (cpu_req)                   nxt = CPU;
        else if (status_q[0] & tx_valid) nxt = TX_WR;
      end
      CPU:       nxt = reinit ? INIT_MODE : POLL_WAIT;
      default:   nxt = POLL_WAIT;
    endcase
  end

  always_comb begin
    st_d   = st_q;
    ph_d   = ph_q;
    scnt_d = scnt_q;
    gap_d  = gap_q;
    unique case (ph_q)
      PH_IDLE: begin
        if (st_q != POLL_WAIT) begin
          ph_d = PH_SETUP;
        end else if (cpu_req) begin
          st_d = CPU;
          ph_d = PH_SETUP;
        end else if (gap_q <= 8'd1) begin
          st_d = STAT_RD;
          ph_d = PH_SETUP;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      PH_SETUP: begin
        ph_d   = PH_STROBE;
        scnt_d = 4'(STROBE_CYC - 1);
      end
      PH_STROBE: begin
        if (scnt_q == 4'd0) ph_d = PH_HOLD;
        else                scnt_d = scnt_q - 4'd1;
      end
      PH_HOLD: ph_d = PH_GAP;
      PH_GAP: begin
        st_d = nxt;
        if (nxt == POLL_WAIT) begin
          ph_d  = PH_IDLE;
          gap_d = 8'(POLL_GAP);
        end else begin
          ph_d = PH_SETUP;
        end
      end
      default: ph_d = PH_IDLE;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    cd_d        = cd_q;
    dout_d      = dout_q;
    samp_d      = samp_q;
    status_d    = status_q;
    cpu_rdata_d = cpu_rdata_q;
    rx_data_d   = rx_data_q;
    init_done_d = init_done_q;
    if (ph_q == PH_SETUP) begin
      we_d   = f_we;
      cd_d   = f_cd;
      dout_d = f_dat;
    end
    if (ph_q == PH_STROBE && scnt_q == 4'd0)
      samp_d = u_din;
    if (ph_q == PH_HOLD && st_q == CPU && !we_q)
      cpu_rdata_d = samp_q;
    if (ph_q == PH_HOLD && st_q == RX_RD)
      rx_data_d = samp_q;
    if (in_gap && st_q == STAT_RD)
      status_d = samp_q;
    if (in_gap && st_q == INIT_CMD)
      init_done_d = 1'b1;
    if (in_gap && st_q == CPU && reinit)
      init_done_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q        <= INIT0;
      ph_q        <= PH_IDLE;
      scnt_q      <= '0;
      gap_q       <= '0;
      we_q        <= 1'b0;
      cd_q        <= 1'b0;
      dout_q      <= '0;
      samp_q      <= '0;
      status_q    <= '0;
      cpu_rdata_q <= '0;
      rx_data_q   <= '0;
      init_done_q <= 1'b0;
    end else begin
      st_q        <= st_d;
      ph_q        <= ph_d;
      scnt_q      <= scnt_d;
      gap_q       <= gap_d;
      we_q        <= we_d;
      cd_q        <= cd_d;
      dout_q      <= dout_d;
      samp_q      <= samp_d;
      status_q    <= status_d;
      cpu_rdata_q <= cpu_rdata_d;
      rx_data_q   <= rx_data_d;
      init_done_q <= init_done_d;
    end
  end

`ifdef USART_RX_FIFO_EN
  logic [7:0] mem_q [4];
  logic [7:0] mem_d [4];
  logic [1:0] wp_q, wp_d, rp_q, rp_d;
  logic [2:0] cnt_q, cnt_d;
  logic       pop;

  assign rx_ok = (cnt_q != 3'd4);
  assign pop   = (cnt_q != 3'd0) & rx_ready;

  always_comb begin
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (rx_push) begin
      mem_d[wp_q] = rx_data_q;
      wp_d        = wp_q + 2'd1;
    end
    if (pop) rp_d = rp_q + 2'd1;
    unique case ({rx_push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  assign rx_valid = (cnt_q != 3'd0);
  assign rx_data  = mem_q[rp_q];
`else
  assign rx_ok    = 1'b1;
  assign rx_valid = rx_push;
  assign rx_data  = rx_data_q;
`endif

  assign busy = (ph_q == PH_SETUP) | (ph_q == PH_STROBE) |
                (ph_q == PH_HOLD);

  always_comb begin
    u_cs_n    = ~busy;
    u_wr_n    = ~((ph_q == PH_STROBE) & cur_we);
    u_rd_n    = ~((ph_q == PH_STROBE) & ~cur_we);
    u_oe      = busy & cur_we;
    u_cd      = cur_cd;
    u_dout    = cur_dat;
    cpu_ack   = (st_q == CPU) & in_gap;
    tx_ready  = (st_q == TX_WR) & (ph_q == PH_SETUP);
    cpu_rdata = cpu_rdata_q;
    status    = status_q;
    init_done = init_done_q;
  end

endmodule
